// File: rtl/axi_burst_mem_pkg.sv
// Shared constants, state types and burst legality helpers for the AXI4 burst memory slave.
package axi_burst_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'd2;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } w_state_t;

  typedef enum logic {
    RIdle,
    RData
  } r_state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic burst_legal(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
    logic ok;
    ok = (size == SIZE_WORD) && (burst != 2'b11);
    if (burst == BURST_WRAP && !wrap_len_ok(len)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/axi_burst_next_addr.sv
// Combinational next-beat byte address for word-sized FIXED/INCR/WRAP bursts.
module axi_burst_next_addr
  import axi_burst_mem_pkg::*;
#(
  parameter int unsigned AddrWidth = 10
) (
  input  logic [AddrWidth-1:0] i_addr,
  input  logic [7:0]           i_len,
  input  logic [1:0]           i_burst,
  output logic [AddrWidth-1:0] o_next_addr
);

  logic [AddrWidth-1:0] w_incr;
  logic [AddrWidth-1:0] w_mask;

  assign w_incr = i_addr + AddrWidth'(4);
  // For legal wrap lengths (len+1)*4-1 is just len with two low ones appended.
  assign w_mask = {{(AddrWidth-6){1'b0}}, i_len[3:0], 2'b11};

  always_comb begin
    o_next_addr = w_incr;
    if (i_burst == BURST_FIXED) begin
      o_next_addr = i_addr;
    end else if (i_burst == BURST_WRAP && wrap_len_ok(i_len)) begin
      o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
    end
  end

endmodule

// File: rtl/axi_burst_mem.sv
// AXI4 slave terminating bursts into an internal word memory; memory survives reset,
// protocol state does not. Read and write channels run independently.
module axi_burst_mem
  import axi_burst_mem_pkg::*;
#(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned MemDepth  = 1 << (C_S_AXI_ADDR_WIDTH - 2);
  localparam int          StrbWidth = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [MemDepth];

  // Write channel state
  w_state_t                      r_wstate;
  logic [C_S_AXI_ID_WIDTH-1:0]   r_awid;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]                    r_awlen;
  logic [1:0]                    r_awburst;
  logic [7:0]                    r_wcnt;
  logic                          r_werr;
  logic [1:0]                    r_bresp;

  // Read channel state; r_araddr always points at the next word to load
  r_state_t                      r_rstate;
  logic [C_S_AXI_ID_WIDTH-1:0]   r_arid;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]                    r_arlen;
  logic [1:0]                    r_arburst;
  logic [7:0]                    r_rcnt;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic                          r_rlast;
  logic [1:0]                    r_rresp;

  logic [C_S_AXI_ADDR_WIDTH-1:0] w_wnext;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_rnext;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_rsrc_addr;
  logic [7:0]                    w_rsrc_len;
  logic [1:0]                    w_rsrc_burst;
  logic                          w_wr_en;
  logic                          w_w_last_beat;
  logic                          w_wlast_bad;
  logic [7:0]                    w_rcnt_inc;

  // Handshake-facing outputs are blanked while reset is asserted.
  assign S_AXI_AWREADY = !ARESET && (r_wstate == WIdle);
  assign S_AXI_WREADY  = !ARESET && (r_wstate == WData);
  assign S_AXI_BVALID  = !ARESET && (r_wstate == WResp);
  assign S_AXI_BID     = r_awid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = !ARESET && (r_rstate == RIdle);
  assign S_AXI_RVALID  = !ARESET && (r_rstate == RData);
  assign S_AXI_RID     = r_arid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RLAST   = r_rlast;
  assign S_AXI_RRESP   = r_rresp;

  assign w_wr_en       = S_AXI_WVALID && S_AXI_WREADY;
  assign w_w_last_beat = (r_wcnt == r_awlen);
  assign w_wlast_bad   = (S_AXI_WLAST != w_w_last_beat);
  assign w_rcnt_inc    = r_rcnt + 8'd1;

  assign w_rsrc_addr  = (r_rstate == RIdle) ? S_AXI_ARADDR  : r_araddr;
  assign w_rsrc_len   = (r_rstate == RIdle) ? S_AXI_ARLEN   : r_arlen;
  assign w_rsrc_burst = (r_rstate == RIdle) ? S_AXI_ARBURST : r_arburst;

  axi_burst_next_addr #(
    .AddrWidth (C_S_AXI_ADDR_WIDTH)
  ) u_wr_next (
    .i_addr      (r_awaddr),
    .i_len       (r_awlen),
    .i_burst     (r_awburst),
    .o_next_addr (w_wnext)
  );

  axi_burst_next_addr #(
    .AddrWidth (C_S_AXI_ADDR_WIDTH)
  ) u_rd_next (
    .i_addr      (w_rsrc_addr),
    .i_len       (w_rsrc_len),
    .i_burst     (w_rsrc_burst),
    .o_next_addr (w_rnext)
  );

  always_ff @(posedge ACLK) begin
    if (w_wr_en) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (S_AXI_WSTRB[b]) begin
          r_mem[r_awaddr[C_S_AXI_ADDR_WIDTH-1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= WIdle;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awburst <= BURST_FIXED;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        WIdle: begin
          if (S_AXI_AWVALID) begin
            r_wstate  <= WData;
            r_awid    <= S_AXI_AWID;
            r_awaddr  <= S_AXI_AWADDR;
            r_awlen   <= S_AXI_AWLEN;
            r_awburst <= S_AXI_AWBURST;
            r_wcnt    <= '0;
            r_werr    <= !burst_legal(S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
            r_bresp   <= RESP_OKAY;
          end
        end
        WData: begin
          if (S_AXI_WVALID) begin
            r_awaddr <= w_wnext;
            r_wcnt   <= r_wcnt + 8'd1;
            // Burst length comes from AWLEN; a misplaced WLAST only taints the response.
            if (w_w_last_beat) begin
              r_wstate <= WResp;
              r_bresp  <= (r_werr || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end else if (w_wlast_bad) begin
              r_werr <= 1'b1;
            end
          end
        end
        WResp: begin
          if (S_AXI_BREADY) r_wstate <= WIdle;
        end
        default: r_wstate <= WIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= RIdle;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arburst <= BURST_FIXED;
      r_rcnt    <= '0;
      r_rdata   <= '0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        RIdle: begin
          if (S_AXI_ARVALID) begin
            r_rstate  <= RData;
            r_arid    <= S_AXI_ARID;
            r_araddr  <= w_rnext;
            r_arlen   <= S_AXI_ARLEN;
            r_arburst <= S_AXI_ARBURST;
            r_rcnt    <= '0;
            r_rdata   <= r_mem[S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]];
            r_rlast   <= (S_AXI_ARLEN == 8'd0);
            r_rresp   <= burst_legal(S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST) ?
                         RESP_OKAY : RESP_SLVERR;
          end
        end
        RData: begin
          if (S_AXI_RREADY) begin
            if (r_rlast) begin
              r_rstate <= RIdle;
              r_rlast  <= 1'b0;
              r_rresp  <= RESP_OKAY;
            end else begin
              r_rdata  <= r_mem[r_araddr[C_S_AXI_ADDR_WIDTH-1:2]];
              r_araddr <= w_rnext;
              r_rcnt   <= w_rcnt_inc;
              r_rlast  <= (w_rcnt_inc == r_arlen);
            end
          end
        end
        default: r_rstate <= RIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mem.sv
// Directed bench for axi_burst_mem: bursts, wrap, strobes, backpressure, errors, reset.
module tb_axi_burst_mem;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [0:0]  awid = '0;
  logic [9:0]  awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 2'b01;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [0:0]  arid = '0;
  logic [9:0]  araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd [16];
  logic        rl [16];
  logic [1:0]  rr [16];
  logic [0:0]  rid_seen;
  int          nbeats;
  int          aw_to_b;
  bit          stall_changed;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_burst_mem #(
    .C_S_AXI_ID_WIDTH   (1),
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (10)
  ) dut (
    .ACLK          (clk),
    .ARESET        (areset),
    .S_AXI_AWID    (awid),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWLEN   (awlen),
    .S_AXI_AWSIZE  (awsize),
    .S_AXI_AWBURST (awburst),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WLAST   (wlast),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BID     (bid),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARID    (arid),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARLEN   (arlen),
    .S_AXI_ARSIZE  (arsize),
    .S_AXI_ARBURST (arburst),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RID     (rid),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [0:0] id, input logic [9:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int last_at,
                          output logic [1:0] resp, output logic [0:0] rsp_id, output bit ok);
    int n;
    int t_aw;
    ok = 1'b1;
    resp = 2'bxx;
    rsp_id = 1'bx;
    aw_to_b = -1;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin step(); n++; end
    if (!awready) begin awvalid = 1'b0; ok = 1'b0; return; end
    t_aw = cyc;
    step();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin step(); n++; end
      if (!wready) begin wvalid = 1'b0; ok = 1'b0; return; end
      step();
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin step(); n++; end
    if (!bvalid) begin
      ok = 1'b0;
    end else begin
      resp = bresp;
      rsp_id = bid;
      aw_to_b = cyc - t_aw;
    end
    step();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [0:0] id, input logic [9:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size,
                         input logic [3:0] rpat, output bit ok);
    int n;
    int k;
    bit done;
    bit stalled;
    logic [31:0] hold_d;
    logic hold_l;
    logic [1:0] hold_r;
    ok = 1'b1;
    nbeats = 0;
    stall_changed = 1'b0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin step(); n++; end
    if (!arready) begin arvalid = 1'b0; ok = 1'b0; return; end
    step();
    arvalid = 1'b0;
    done = 1'b0;
    stalled = 1'b0;
    hold_d = '0; hold_l = 1'b0; hold_r = '0;
    k = 0;
    while (!done && k < 200) begin
      rready = rpat[k % 4];
      if (stalled && (rdata !== hold_d || rlast !== hold_l || rresp !== hold_r))
        stall_changed = 1'b1;
      if (rvalid && rready) begin
        if (nbeats < 16) begin
          rd[nbeats] = rdata; rl[nbeats] = rlast; rr[nbeats] = rresp;
        end
        rid_seen = rid;
        nbeats++;
        if (rlast) done = 1'b1;
      end
      stalled = rvalid && !rready;
      hold_d = rdata; hold_l = rlast; hold_r = rresp;
      step();
      k++;
    end
    rready = 1'b0;
    if (!done) ok = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    step();
    step();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshake: got %b expected 000000",
               {awready, wready, bvalid, arready, rvalid, rlast});
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata);
    end
    checks++;
    if ({bresp, rresp} !== 4'b0) begin
      errors++; $display("FAIL reset_resp: got %b expected 0000", {bresp, rresp});
    end
    areset = 1'b0;
    #1;
    checks++;
    if ({awready, arready} !== 2'b11) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 11", {awready, arready});
    end
    step();
  endtask

  task automatic test_incr();
    logic [1:0] resp;
    logic [0:0] rsp_id;
    bit ok;
    logic [7:0] lasts;
    for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(1'b0, 10'h000, 8'd7, 2'b01, 3'd2, 7, resp, rsp_id, ok);
    checks++;
    if (ok !== 1'b1 || resp !== 2'b00 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL incr_write_resp: got ok=%0d resp=%b id=%b expected 1/00/0",
                         ok, resp, rsp_id);
    end
    checks++;
    if (aw_to_b !== 9) begin
      errors++; $display("FAIL incr_aw_to_b: got %0d expected 9", aw_to_b);
    end
    do_read(1'b1, 10'h000, 8'd7, 2'b01, 3'd2, 4'b1111, ok);
    checks++;
    if (ok !== 1'b1 || nbeats !== 8 || rid_seen !== 1'b1) begin
      errors++; $display("FAIL incr_read_beats: got ok=%0d beats=%0d rid=%b expected 1/8/1",
                         ok, nbeats, rid_seen);
    end
    lasts = '0;
    for (int i = 0; i < 8; i++) begin
      lasts[i] = rl[i];
      checks++;
      if (rd[i] !== 32'(i + 1) || rr[i] !== 2'b00) begin
        errors++; $display("FAIL incr_read_data[%0d]: got %h/%b expected %h/00",
                           i, rd[i], rr[i], 32'(i + 1));
      end
    end
    checks++;
    if (lasts !== 8'b1000_0000) begin
      errors++; $display("FAIL incr_rlast: got %b expected 10000000", lasts);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] resp;
    logic [0:0] rsp_id;
    bit ok;
    logic [31:0] exp_inc [4];
    logic [31:0] exp_wrp [4];
    wd[0] = 32'hAAAA_0000; wd[1] = 32'hBBBB_0000; wd[2] = 32'hCCCC_0000; wd[3] = 32'hDDDD_0000;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    do_write(1'b1, 10'h008, 8'd3, 2'b10, 3'd2, 3, resp, rsp_id, ok);
    checks++;
    if (ok !== 1'b1 || resp !== 2'b00 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL wrap_write_resp: got ok=%0d resp=%b id=%b expected 1/00/1",
                         ok, resp, rsp_id);
    end
    exp_inc[0] = 32'hCCCC_0000; exp_inc[1] = 32'hDDDD_0000;
    exp_inc[2] = 32'hAAAA_0000; exp_inc[3] = 32'hBBBB_0000;
    do_read(1'b0, 10'h000, 8'd3, 2'b01, 3'd2, 4'b1111, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ok !== 1'b1 || rd[i] !== exp_inc[i]) begin
        errors++; $display("FAIL wrap_incr_readback[%0d]: got %h expected %h",
                           i, rd[i], exp_inc[i]);
      end
    end
    exp_wrp[0] = 32'hBBBB_0000; exp_wrp[1] = 32'hCCCC_0000;
    exp_wrp[2] = 32'hDDDD_0000; exp_wrp[3] = 32'hAAAA_0000;
    do_read(1'b0, 10'h00C, 8'd3, 2'b10, 3'd2, 4'b1111, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ok !== 1'b1 || rd[i] !== exp_wrp[i] || rr[i] !== 2'b00) begin
        errors++; $display("FAIL wrap_read[%0d]: got %h/%b expected %h/00",
                           i, rd[i], rr[i], exp_wrp[i]);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [0:0] rsp_id;
    bit ok;
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_write(1'b0, 10'h010, 8'd0, 2'b01, 3'd2, 0, resp, rsp_id, ok);
    wd[0] = 32'h1234_5678; ws[0] = 4'h5;
    do_write(1'b0, 10'h010, 8'd0, 2'b01, 3'd2, 0, resp, rsp_id, ok);
    do_read(1'b0, 10'h010, 8'd0, 2'b01, 3'd2, 4'b1111, ok);
    checks++;
    if (ok !== 1'b1 || nbeats !== 1 || rd[0] !== 32'hFF34_FF78 || rl[0] !== 1'b1) begin
      errors++; $display("FAIL strobe_readback: got %h last=%b beats=%0d expected ff34ff78/1/1",
                         rd[0], rl[0], nbeats);
    end
  endtask

  task automatic test_fixed();
    logic [1:0] resp;
    logic [0:0] rsp_id;
    bit ok;
    wd[0] = 32'h2424_2424; ws[0] = 4'hF;
    do_write(1'b0, 10'h024, 8'd0, 2'b01, 3'd2, 0, resp, rsp_id, ok);
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    do_write(1'b0, 10'h020, 8'd3, 2'b00, 3'd2, 3, resp, rsp_id, ok);
    checks++;
    if (ok !== 1'b1 || resp !== 2'b00) begin
      errors++; $display("FAIL fixed_write_resp: got ok=%0d resp=%b expected 1/00", ok, resp);
    end
    do_read(1'b0, 10'h020, 8'd1, 2'b01, 3'd2, 4'b1111, ok);
    checks++;
    if (ok !== 1'b1 || rd[0] !== 32'h44 || rd[1] !== 32'h2424_2424) begin
      errors++; $display("FAIL fixed_readback: got %h %h expected 00000044 24242424",
                         rd[0], rd[1]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [3:0] lasts;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hCCCC_0000; exp_d[1] = 32'hDDDD_0000;
    exp_d[2] = 32'hAAAA_0000; exp_d[3] = 32'hBBBB_0000;
    do_read(1'b1, 10'h000, 8'd3, 2'b01, 3'd2, 4'b1001, ok);
    checks++;
    if (ok !== 1'b1 || nbeats !== 4) begin
      errors++; $display("FAIL bp_handshakes: got ok=%0d beats=%0d expected 1/4", ok, nbeats);
    end
    checks++;
    if (stall_changed !== 1'b0) begin
      errors++; $display("FAIL bp_stall_stable: got changed=%0d expected 0", stall_changed);
    end
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL bp_rvalid_after_last: got %b expected 0", rvalid);
    end
    lasts = '0;
    for (int i = 0; i < 4; i++) begin
      lasts[i] = rl[i];
      checks++;
      if (rd[i] !== exp_d[i]) begin
        errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, rd[i], exp_d[i]);
      end
    end
    checks++;
    if (lasts !== 4'b1000) begin
      errors++; $display("FAIL bp_rlast: got %b expected 1000", lasts);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp;
    logic [0:0] rsp_id;
    bit ok;
    wd[0] = 32'h5; ws[0] = 4'hF;
    do_write(1'b0, 10'h030, 8'd0, 2'b01, 3'd1, 0, resp, rsp_id, ok);
    checks++;
    if (ok !== 1'b1 || resp !== 2'b10) begin
      errors++; $display("FAIL err_awsize: got ok=%0d resp=%b expected 1/10", ok, resp);
    end
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h3000_0000 + 32'(i); ws[i] = 4'hF; end
    do_write(1'b1, 10'h030, 8'd3, 2'b01, 3'd2, 1, resp, rsp_id, ok);
    checks++;
    if (ok !== 1'b1 || resp !== 2'b10 || aw_to_b !== 5) begin
      errors++; $display("FAIL err_early_wlast: got ok=%0d resp=%b lat=%0d expected 1/10/5",
                         ok, resp, aw_to_b);
    end
    do_read(1'b0, 10'h030, 8'd3, 2'b01, 3'd2, 4'b1111, ok);
    checks++;
    if (ok !== 1'b1 || rd[1] !== 32'h3000_0001 || rd[3] !== 32'h3000_0003) begin
      errors++; $display("FAIL err_data_kept: got %h %h expected 30000001 30000003",
                         rd[1], rd[3]);
    end
    do_write(1'b0, 10'h030, 8'd2, 2'b10, 3'd2, 2, resp, rsp_id, ok);
    checks++;
    if (ok !== 1'b1 || resp !== 2'b10) begin
      errors++; $display("FAIL err_wrap_len: got ok=%0d resp=%b expected 1/10", ok, resp);
    end
    do_read(1'b0, 10'h030, 8'd0, 2'b11, 3'd2, 4'b1111, ok);
    checks++;
    if (ok !== 1'b1 || rr[0] !== 2'b10) begin
      errors++; $display("FAIL err_arburst: got ok=%0d resp=%b expected 1/10", ok, rr[0]);
    end
    do_read(1'b0, 10'h030, 8'd1, 2'b01, 3'd0, 4'b1111, ok);
    checks++;
    if (ok !== 1'b1 || rr[0] !== 2'b10 || rr[1] !== 2'b10) begin
      errors++; $display("FAIL err_arsize: got %b %b expected 10 10", rr[0], rr[1]);
    end
    wd[0] = 32'h3C; ws[0] = 4'hF;
    do_write(1'b0, 10'h03C, 8'd0, 2'b01, 3'd2, 0, resp, rsp_id, ok);
    checks++;
    if (ok !== 1'b1 || resp !== 2'b00) begin
      errors++; $display("FAIL err_cleared: got ok=%0d resp=%b expected 1/00", ok, resp);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp;
    logic [0:0] rsp_id;
    bit ok;
    bit seen_b;
    bit stuck;
    int n;
    logic [31:0] exp_v;
    for (int i = 0; i < 8; i++) begin wd[i] = 32'hBBBB_0000 | 32'(i); ws[i] = 4'hF; end
    do_write(1'b0, 10'h040, 8'd7, 2'b01, 3'd2, 7, resp, rsp_id, ok);
    stuck = 1'b0;
    awaddr = 10'h040; awlen = 8'd7; awburst = 2'b01; awsize = 3'd2; awid = 1'b1;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin step(); n++; end
    if (!awready) stuck = 1'b1;
    step();
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wdata = 32'hC000_0000 | 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin step(); n++; end
      if (!wready) stuck = 1'b1;
      step();
    end
    wvalid = 1'b0;
    checks++;
    if (stuck !== 1'b0) begin
      errors++; $display("FAIL rstmid_setup: got stuck=%0d expected 0", stuck);
    end
    areset = 1'b1;
    step();
    areset = 1'b0;
    #1;
    checks++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready: got awready=%b bvalid=%b expected 1/0",
                         awready, bvalid);
    end
    bready = 1'b1;
    seen_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bvalid) seen_b = 1'b1;
      step();
    end
    bready = 1'b0;
    checks++;
    if (seen_b !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_b: got bvalid_seen=%0d expected 0", seen_b);
    end
    do_read(1'b0, 10'h040, 8'd7, 2'b01, 3'd2, 4'b1111, ok);
    for (int i = 0; i < 8; i++) begin
      exp_v = (i < 3) ? (32'hC000_0000 | 32'(i)) : (32'hBBBB_0000 | 32'(i));
      checks++;
      if (ok !== 1'b1 || rd[i] !== exp_v) begin
        errors++; $display("FAIL rstmid_readback[%0d]: got %h expected %h", i, rd[i], exp_v);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_fixed();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
